// File: rtl/strip_placement_ctrl.sv
// Sequential placement controller for the three-strip placement datapath.
// Tracks strip occupancy, checks fit against the selector's choice and returns the placement result.
module strip_placement_ctrl #(
  parameter int STRIP_WIDTH = 128,
  parameter int W_BITS      = 8,
  parameter int CNT_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                req_valid,
  input  logic [W_BITS-1:0]   req_width,
  output logic                req_ready,
  output logic [W_BITS-1:0]   occupied_width_1,
  output logic [W_BITS-1:0]   occupied_width_2,
  output logic [W_BITS-1:0]   occupied_width_3,
  input  logic [1:0]          min_occupied_width_no,
  output logic                place_valid,
  output logic                place_reject,
  output logic [1:0]          place_strip,
  output logic [W_BITS-1:0]   place_x,
  output logic [CNT_BITS-1:0] place_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  localparam logic [W_BITS:0] StripLimit = (W_BITS+1)'(STRIP_WIDTH);

  state_e              state_q;
  logic [W_BITS-1:0]   occ1_q, occ2_q, occ3_q;
  logic [W_BITS-1:0]   wReg_q;
  logic [W_BITS-1:0]   placeX_q;
  logic [1:0]          placeStrip_q;
  logic                placeValid_q;
  logic                placeReject_q;
  logic [CNT_BITS-1:0] count_q;

  logic [W_BITS-1:0]   occSel;
  logic [W_BITS:0]     occSum_d;
  logic                fit;

  // The sum carries one extra bit so an oversized program can never wrap into a false fit.
  always_comb begin
    occSel = '0;
    case (min_occupied_width_no)
      2'd1:    occSel = occ1_q;
      2'd2:    occSel = occ2_q;
      2'd3:    occSel = occ3_q;
      default: occSel = '0;
    endcase
    occSum_d = {1'b0, occSel} + {1'b0, wReg_q};
    fit      = (wReg_q != '0) && (min_occupied_width_no != 2'd0) && (occSum_d <= StripLimit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      occ1_q        <= '0;
      occ2_q        <= '0;
      occ3_q        <= '0;
      wReg_q        <= '0;
      placeX_q      <= '0;
      placeStrip_q  <= 2'd0;
      placeValid_q  <= 1'b0;
      placeReject_q <= 1'b0;
      count_q       <= '0;
    end else begin
      placeValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            occ1_q  <= '0;
            occ2_q  <= '0;
            occ3_q  <= '0;
            count_q <= '0;
          end else if (req_valid) begin
            wReg_q  <= req_width;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          state_q      <= RESP;
          placeValid_q <= 1'b1;
          if (fit) begin
            case (min_occupied_width_no)
              2'd1:    occ1_q <= occSum_d[W_BITS-1:0];
              2'd2:    occ2_q <= occSum_d[W_BITS-1:0];
              2'd3:    occ3_q <= occSum_d[W_BITS-1:0];
              default: ;
            endcase
            placeX_q      <= occSel;
            placeStrip_q  <= min_occupied_width_no;
            placeReject_q <= 1'b0;
            if (count_q != '1) count_q <= count_q + CNT_BITS'(1);
          end else begin
            placeX_q      <= '0;
            placeStrip_q  <= 2'd0;
            placeReject_q <= 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = (state_q == IDLE) && !clear;
  assign occupied_width_1 = occ1_q;
  assign occupied_width_2 = occ2_q;
  assign occupied_width_3 = occ3_q;
  assign place_valid      = placeValid_q;
  assign place_reject     = placeReject_q;
  assign place_strip      = placeStrip_q;
  assign place_x          = placeX_q;
  assign place_count      = count_q;

endmodule

// File: tb/tb_strip_placement_ctrl.sv
// Directed bench for strip_placement_ctrl with a lowest-index-wins minimum selector model.
module tb_strip_placement_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       req_valid;
  logic [7:0] req_width;
  logic       req_ready;
  logic [7:0] occupied_width_1, occupied_width_2, occupied_width_3;
  logic [1:0] min_occupied_width_no;
  logic       place_valid, place_reject;
  logic [1:0] place_strip;
  logic [7:0] place_x;
  logic [7:0] place_count;

  logic       forceSel = 1'b0;
  logic [1:0] selModel;
  logic [7:0] minOcc;
  int         checkCount = 0;
  int         failCount = 0;

  strip_placement_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clear                 (clear),
    .req_valid             (req_valid),
    .req_width             (req_width),
    .req_ready             (req_ready),
    .occupied_width_1      (occupied_width_1),
    .occupied_width_2      (occupied_width_2),
    .occupied_width_3      (occupied_width_3),
    .min_occupied_width_no (min_occupied_width_no),
    .place_valid           (place_valid),
    .place_reject          (place_reject),
    .place_strip           (place_strip),
    .place_x               (place_x),
    .place_count           (place_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the external selector: smallest occupancy wins, ties go to the lowest strip.
  always_comb begin
    selModel = 2'd1;
    minOcc   = occupied_width_1;
    if (occupied_width_2 < minOcc) begin
      selModel = 2'd2;
      minOcc   = occupied_width_2;
    end
    if (occupied_width_3 < minOcc) begin
      selModel = 2'd3;
      minOcc   = occupied_width_3;
    end
  end

  assign min_occupied_width_no = forceSel ? 2'd0 : selModel;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkOcc(input string tag, input int e1, input int e2, input int e3, input int eCnt);
    checkOutput({tag, " occ1"}, 32'(occupied_width_1), 32'(e1));
    checkOutput({tag, " occ2"}, 32'(occupied_width_2), 32'(e2));
    checkOutput({tag, " occ3"}, 32'(occupied_width_3), 32'(e3));
    checkOutput({tag, " count"}, 32'(place_count), 32'(eCnt));
  endtask

  // Issue one request from a negedge and check the strobe, its latency and the result fields.
  task automatic applyStimulus(input string tag, input logic [7:0] w, input int eStrip, input int eX, input int eRej);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) checkOutput({tag, " ready wait"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_width = w;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!place_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " valid"}, 32'(place_valid), 32'd1);
    checkOutput({tag, " latency"}, 32'(cyc), 32'd2);
    checkOutput({tag, " strip"}, 32'(place_strip), 32'(eStrip));
    checkOutput({tag, " x"}, 32'(place_x), 32'(eX));
    checkOutput({tag, " reject"}, 32'(place_reject), 32'(eRej));
    @(negedge clk);
    checkOutput({tag, " valid drop"}, 32'(place_valid), 32'd0);
    checkOutput({tag, " ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int sawValid;
    rst_n     = 1'b0;
    clear     = 1'b0;
    req_valid = 1'b0;
    req_width = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset ready", 32'(req_ready), 32'd1);
    checkOutput("reset valid", 32'(place_valid), 32'd0);
    checkOutput("reset reject", 32'(place_reject), 32'd0);
    checkOutput("reset strip", 32'(place_strip), 32'd0);
    checkOutput("reset x", 32'(place_x), 32'd0);
    checkOcc("reset", 0, 0, 0, 0);

    applyStimulus("w40 a", 8'd40, 1, 0, 0);
    applyStimulus("w40 b", 8'd40, 2, 0, 0);
    applyStimulus("w40 c", 8'd40, 3, 0, 0);
    checkOcc("after 3x40", 40, 40, 40, 3);

    applyStimulus("w88 exact", 8'd88, 1, 40, 0);
    checkOcc("exact fill", 128, 40, 40, 4);
    applyStimulus("w100 over", 8'd100, 0, 0, 1);
    checkOcc("over reject", 128, 40, 40, 4);

    applyStimulus("w88 s2", 8'd88, 2, 40, 0);
    applyStimulus("w88 s3", 8'd88, 3, 40, 0);
    checkOcc("all full", 128, 128, 128, 6);
    applyStimulus("w1 full", 8'd1, 0, 0, 1);
    checkOcc("full reject", 128, 128, 128, 6);

    clear     = 1'b1;
    req_valid = 1'b1;
    req_width = 8'd16;
    #1;
    checkOutput("clear ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear     = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOcc("cleared", 0, 0, 0, 0);
    checkOutput("clear no accept", 32'(req_ready), 32'd1);
    checkOutput("clear no valid", 32'(place_valid), 32'd0);
    @(negedge clk);
    applyStimulus("w16 post clear", 8'd16, 1, 0, 0);
    checkOcc("post clear", 16, 0, 0, 1);

    applyStimulus("w0", 8'd0, 0, 0, 1);
    checkOcc("w0 no change", 16, 0, 0, 1);
    forceSel = 1'b1;
    applyStimulus("sel0", 8'd8, 0, 0, 1);
    forceSel = 1'b0;
    checkOcc("sel0 no change", 16, 0, 0, 1);

    applyStimulus("w30 s2", 8'd30, 2, 0, 0);
    checkOcc("before reset", 16, 30, 0, 2);

    req_valid = 1'b1;
    req_width = 8'd8;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("eval reset ready", 32'(req_ready), 32'd1);
    checkOutput("eval reset valid", 32'(place_valid), 32'd0);
    checkOutput("eval reset strip", 32'(place_strip), 32'd0);
    checkOutput("eval reset x", 32'(place_x), 32'd0);
    checkOcc("eval reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (place_valid) sawValid = 1;
    end
    checkOutput("eval reset dropped", 32'(sawValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
